mdu_iter: RTL and testbench

Iterative multiply/divide unit implementing the RV32M operations for the execute stage. It sits beside the combinational `alu` and shares its operand buses. Operations with long latency are issued through a valid/ready handshake, and the result is held until the pipeline accepts it. The unit is parametrised in operand width, supports signed, unsigned and mixed-sign forms, handles the RISC-V divide corner cases, and supports mid-operation flush.

---
 rtl/mdu_iter_pkg.sv | 32 +++
 rtl/mdu_iter_if.sv | 25 ++
 rtl/mdu_divstep.sv | 23 ++
 rtl/mdu_iter.sv | 165 ++++++++++++++++
 tb/tb_mdu_iter.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_iter_pkg.sv
// rtl/mdu_iter_pkg.sv - RV32M opcodes, FSM states and operand-signedness helpers for mdu_iter
package mdu_iter_pkg;

    localparam logic [2:0] FUNCT3_MUL    = 3'd0;
    localparam logic [2:0] FUNCT3_MULH   = 3'd1;
    localparam logic [2:0] FUNCT3_MULHSU = 3'd2;
    localparam logic [2:0] FUNCT3_MULHU  = 3'd3;
    localparam logic [2:0] FUNCT3_DIV    = 3'd4;
    localparam logic [2:0] FUNCT3_DIVU   = 3'd5;
    localparam logic [2:0] FUNCT3_REM    = 3'd6;
    localparam logic [2:0] FUNCT3_REMU   = 3'd7;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

    // MUL only keeps the low half, which is identical for either signedness
    function automatic logic rs1_signed(input logic [2:0] f);
        return (f == FUNCT3_MUL) || (f == FUNCT3_MULH) || (f == FUNCT3_MULHSU) ||
               (f == FUNCT3_DIV) || (f == FUNCT3_REM);
    endfunction

    function automatic logic rs2_signed(input logic [2:0] f);
        return (f == FUNCT3_MUL) || (f == FUNCT3_MULH) ||
               (f == FUNCT3_DIV) || (f == FUNCT3_REM);
    endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// rtl/mdu_iter_if.sv - request/result handshake bundle between the execute stage and mdu_iter
interface mdu_iter_if #(parameter int XLEN = 32);

    logic            mdu_flush_in;
    logic            mdu_valid_in;
    logic            mdu_ready_out;
    logic [2:0]      mdu_funct3_in;
    logic [XLEN-1:0] mdu_arg1_in;
    logic [XLEN-1:0] mdu_arg2_in;
    logic            mdu_valid_out;
    logic            mdu_ready_in;
    logic [XLEN-1:0] mdu_arg_out;
    logic            mdu_busy_out;

    modport master (
        output mdu_flush_in, mdu_valid_in, mdu_funct3_in, mdu_arg1_in, mdu_arg2_in, mdu_ready_in,
        input  mdu_ready_out, mdu_valid_out, mdu_arg_out, mdu_busy_out
    );

    modport slave (
        input  mdu_flush_in, mdu_valid_in, mdu_funct3_in, mdu_arg1_in, mdu_arg2_in, mdu_ready_in,
        output mdu_ready_out, mdu_valid_out, mdu_arg_out, mdu_busy_out
    );

endinterface

// File: rtl/mdu_divstep.sv
// rtl/mdu_divstep.sv - one combinational restoring-division step
module mdu_divstep #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic            dbit,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic            q_bit
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // rem < divisor on entry, so the restored value always fits back in XLEN bits
    always_comb begin
        shifted  = {rem, dbit};
        diff     = shifted - {1'b0, divisor};
        q_bit    = (shifted >= {1'b0, divisor});
        rem_next = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    end

endmodule

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative RV32M multiply/divide unit; optional MDU_FAST_MUL_EN single-cycle multiply
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic       clk_in,
    input  logic       rst_in,
    mdu_iter_if.slave  mdu
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e        state;
    logic [2:0]        op;
    logic              neg_res;
    logic [CW-1:0]     count;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   operand;
    logic [XLEN-1:0]   arg_res;
    logic              ready_r;
    logic              valid_r;
    logic              busy_r;

    logic              s1, s2, a_neg, b_neg, is_div, div_zero, div_ovf, fast_mul;
    logic [XLEN-1:0]   a_mag, b_mag, early_res, fast_res;

    always_comb begin
        s1       = rs1_signed(mdu.mdu_funct3_in);
        s2       = rs2_signed(mdu.mdu_funct3_in);
        a_neg    = s1 & mdu.mdu_arg1_in[XLEN-1];
        b_neg    = s2 & mdu.mdu_arg2_in[XLEN-1];
        a_mag    = a_neg ? -mdu.mdu_arg1_in : mdu.mdu_arg1_in;
        b_mag    = b_neg ? -mdu.mdu_arg2_in : mdu.mdu_arg2_in;
        is_div   = mdu.mdu_funct3_in[2];
        div_zero = is_div && (mdu.mdu_arg2_in == '0);
        div_ovf  = is_div && s2 && (mdu.mdu_arg1_in == INT_MIN) && (mdu.mdu_arg2_in == '1);
    end

`ifdef MDU_FAST_MUL_EN
    logic signed [XLEN:0]     fast_a, fast_b;
    logic signed [2*XLEN+1:0] fast_prod;

    always_comb begin
        fast_a    = {s1 & mdu.mdu_arg1_in[XLEN-1], mdu.mdu_arg1_in};
        fast_b    = {s2 & mdu.mdu_arg2_in[XLEN-1], mdu.mdu_arg2_in};
        fast_prod = fast_a * fast_b;
        fast_mul  = !is_div;
        fast_res  = (mdu.mdu_funct3_in == FUNCT3_MUL) ? fast_prod[XLEN-1:0]
                                                       : fast_prod[2*XLEN-1:XLEN];
    end
`else
    always_comb begin
        fast_mul = 1'b0;
        fast_res = '0;
    end
`endif

    // results that skip CALC: REM/REMU have funct3[1] set
    always_comb begin
        early_res = fast_res;
        if (div_zero)
            early_res = mdu.mdu_funct3_in[1] ? mdu.mdu_arg1_in : '1;
        else if (div_ovf)
            early_res = mdu.mdu_funct3_in[1] ? '0 : mdu.mdu_arg1_in;
    end

    logic [XLEN:0]     mul_sum;
    logic [XLEN-1:0]   rem_next;
    logic              q_bit;
    logic [2*XLEN-1:0] acc_next;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   calc_res;

    mdu_divstep #(.XLEN(XLEN)) u_divstep (
        .rem      (acc[2*XLEN-1:XLEN]),
        .dbit     (acc[XLEN-1]),
        .divisor  (operand),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
        acc_next = op[2] ? {rem_next, acc[XLEN-2:0], q_bit}
                         : {mul_sum, acc[XLEN-1:1]};
        prod_fix = neg_res ? -acc_next : acc_next;
        if (op == FUNCT3_MUL)
            calc_res = prod_fix[XLEN-1:0];
        else if (!op[2])
            calc_res = prod_fix[2*XLEN-1:XLEN];
        else if (op[1])
            calc_res = neg_res ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
        else
            calc_res = neg_res ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state   <= MDU_IDLE;
            op      <= '0;
            neg_res <= 1'b0;
            count   <= '0;
            acc     <= '0;
            operand <= '0;
            arg_res <= '0;
            ready_r <= 1'b0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
        end else if (mdu.mdu_flush_in) begin
            state   <= MDU_IDLE;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            case (state)
                MDU_IDLE: begin
                    ready_r <= 1'b1;
                    if (mdu.mdu_valid_in && ready_r) begin
                        op      <= mdu.mdu_funct3_in;
                        neg_res <= (is_div && mdu.mdu_funct3_in[1]) ? a_neg : (a_neg ^ b_neg);
                        count   <= CW'(XLEN - 1);
                        acc     <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
                        operand <= is_div ? b_mag : a_mag;
                        ready_r <= 1'b0;
                        busy_r  <= 1'b1;
                        if (div_zero || div_ovf || fast_mul) begin
                            arg_res <= early_res;
                            valid_r <= 1'b1;
                            state   <= MDU_DONE;
                        end else begin
                            state   <= MDU_CALC;
                        end
                    end
                end
                MDU_CALC: begin
                    acc   <= acc_next;
                    count <= count - 1'b1;
                    if (count == '0) begin
                        arg_res <= calc_res;
                        valid_r <= 1'b1;
                        state   <= MDU_DONE;
                    end
                end
                MDU_DONE: begin
                    if (mdu.mdu_ready_in) begin
                        state   <= MDU_IDLE;
                        valid_r <= 1'b0;
                        busy_r  <= 1'b0;
                        ready_r <= 1'b1;
                    end
                end
                default: state <= MDU_IDLE;
            endcase
        end
    end

    assign mdu.mdu_ready_out = ready_r;
    assign mdu.mdu_valid_out = valid_r;
    assign mdu.mdu_arg_out   = arg_res;
    assign mdu.mdu_busy_out  = busy_r;

endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - self-checking bench for mdu_iter against an arithmetic reference model
module tb_mdu_iter;

    localparam int XLEN = 32;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    mdu_iter_if #(.XLEN(XLEN)) bus ();

    mdu_iter #(.XLEN(XLEN)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .mdu    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ub;
        logic [63:0] p;
        int ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        ia = a;
        ib = b;
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (!f[2]) begin
`ifdef MDU_FAST_MUL_EN
            return 1;
`else
            return XLEN + 1;
`endif
        end
        if (b == 0) return 1;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 1;
    endfunction

    task automatic do_op(input string name, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input int hold);
        logic [31:0] exp_res;
        logic [31:0] held;
        int exp_lat;
        int lat;
        exp_res = ref_result(f, a, b);
        exp_lat = ref_latency(f, a, b);
        @(negedge clk);
        n_checks++;
        if (bus.mdu_ready_out !== 1'b1) $display("FAIL %s ready_before_accept: got %b want 1", name, bus.mdu_ready_out);
        else n_pass++;
        bus.mdu_ready_in  = (hold == 0);
        bus.mdu_valid_in  = 1'b1;
        bus.mdu_funct3_in = f;
        bus.mdu_arg1_in   = a;
        bus.mdu_arg2_in   = b;
        @(posedge clk);
        #1;
        bus.mdu_valid_in  = 1'b0;
        bus.mdu_funct3_in = 3'($urandom);
        bus.mdu_arg1_in   = $urandom;
        bus.mdu_arg2_in   = $urandom;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.mdu_valid_out && lat < 100);
        n_checks++;
        if (bus.mdu_valid_out !== 1'b1 || lat != exp_lat)
            $display("FAIL %s latency: got %0d (valid=%b) want %0d", name, lat, bus.mdu_valid_out, exp_lat);
        else n_pass++;
        n_checks++;
        if (bus.mdu_arg_out !== exp_res) $display("FAIL %s result: got %h want %h", name, bus.mdu_arg_out, exp_res);
        else n_pass++;
        n_checks++;
        if (bus.mdu_ready_out !== 1'b0 || bus.mdu_busy_out !== 1'b1)
            $display("FAIL %s done_flags: got ready=%b busy=%b want ready=0 busy=1", name, bus.mdu_ready_out, bus.mdu_busy_out);
        else n_pass++;
        if (hold > 0) begin
            held = bus.mdu_arg_out;
            repeat (hold) begin
                @(negedge clk);
                n_checks++;
                if (bus.mdu_arg_out !== held || bus.mdu_valid_out !== 1'b1 || bus.mdu_ready_out !== 1'b0)
                    $display("FAIL %s backpressure: got arg=%h valid=%b ready=%b want arg=%h valid=1 ready=0",
                             name, bus.mdu_arg_out, bus.mdu_valid_out, bus.mdu_ready_out, held);
                else n_pass++;
            end
            bus.mdu_ready_in = 1'b1;
            @(negedge clk);
            n_checks++;
            if (bus.mdu_ready_out !== 1'b1 || bus.mdu_valid_out !== 1'b0 || bus.mdu_busy_out !== 1'b0)
                $display("FAIL %s release: got ready=%b valid=%b busy=%b want 1 0 0",
                         name, bus.mdu_ready_out, bus.mdu_valid_out, bus.mdu_busy_out);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.mdu_flush_in = 1'b0;
        bus.mdu_valid_in = 1'b0;
        bus.mdu_ready_in = 1'b1;
        bus.mdu_funct3_in = '0;
        bus.mdu_arg1_in = '0;
        bus.mdu_arg2_in = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.mdu_ready_out !== 1'b0 || bus.mdu_valid_out !== 1'b0 || bus.mdu_busy_out !== 1'b0 || bus.mdu_arg_out !== '0)
            $display("FAIL reset_state: got ready=%b valid=%b busy=%b arg=%h want 0 0 0 0",
                     bus.mdu_ready_out, bus.mdu_valid_out, bus.mdu_busy_out, bus.mdu_arg_out);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.mdu_ready_out !== 1'b1) $display("FAIL ready_after_reset: got %b want 1", bus.mdu_ready_out);
        else n_pass++;
    endtask

    task automatic test_directed();
        do_op("div_neg7_2",   3'd4, 32'hFFFF_FFF9, 32'd2, 0);
        do_op("rem_neg7_2",   3'd6, 32'hFFFF_FFF9, 32'd2, 0);
        do_op("divu_by_zero", 3'd5, 32'd100, 32'd0, 0);
        do_op("remu_by_zero", 3'd7, 32'd100, 32'd0, 0);
        do_op("div_by_zero",  3'd4, 32'hFFFF_FFF0, 32'd0, 0);
        do_op("rem_by_zero",  3'd6, 32'hFFFF_FFF0, 32'd0, 0);
        do_op("div_overflow", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op("rem_overflow", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op("divu_no_ovf",  3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op("mulh_min_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 0);
        do_op("mulhsu_m1_2",  3'd2, 32'hFFFF_FFFF, 32'd2, 0);
        do_op("mul_min_min",  3'd0, 32'h8000_0000, 32'h8000_0000, 0);
        do_op("mulhu_max",    3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    endtask

    task automatic test_backpressure();
        do_op("bp_div",  3'd4, 32'd1000, 32'hFFFF_FFF9, 5);
        do_op("bp_divz", 3'd5, 32'd7, 32'd0, 3);
    endtask

    task automatic test_flush();
        int seen;
        @(negedge clk);
        bus.mdu_ready_in  = 1'b1;
        bus.mdu_valid_in  = 1'b1;
        bus.mdu_funct3_in = 3'd5;
        bus.mdu_arg1_in   = 32'd123456;
        bus.mdu_arg2_in   = 32'd7;
        @(posedge clk);
        #1;
        bus.mdu_valid_in = 1'b0;
        repeat (10) @(negedge clk);
        bus.mdu_flush_in = 1'b1;
        @(posedge clk);
        #1;
        bus.mdu_flush_in = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.mdu_ready_out !== 1'b1 || bus.mdu_valid_out !== 1'b0 || bus.mdu_busy_out !== 1'b0)
            $display("FAIL flush_calc: got ready=%b valid=%b busy=%b want 1 0 0",
                     bus.mdu_ready_out, bus.mdu_valid_out, bus.mdu_busy_out);
        else n_pass++;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.mdu_valid_out !== 1'b0) seen++;
        end
        n_checks++;
        if (seen != 0) $display("FAIL flush_no_valid: got %0d valid cycles want 0", seen);
        else n_pass++;
        do_op("mulhu_after_flush", 3'd3, 32'd3, 32'd5, 0);

        // flush together with the result handshake
        @(negedge clk);
        bus.mdu_valid_in  = 1'b1;
        bus.mdu_funct3_in = 3'd5;
        bus.mdu_arg1_in   = 32'd9;
        bus.mdu_arg2_in   = 32'd0;
        @(posedge clk);
        #1;
        bus.mdu_valid_in = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.mdu_valid_out !== 1'b1) $display("FAIL flush_hs_valid: got %b want 1", bus.mdu_valid_out);
        else n_pass++;
        bus.mdu_flush_in = 1'b1;
        @(posedge clk);
        #1;
        bus.mdu_flush_in = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.mdu_ready_out !== 1'b1 || bus.mdu_valid_out !== 1'b0 || bus.mdu_busy_out !== 1'b0)
            $display("FAIL flush_hs_idle: got ready=%b valid=%b busy=%b want 1 0 0",
                     bus.mdu_ready_out, bus.mdu_valid_out, bus.mdu_busy_out);
        else n_pass++;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            do_op("random", 3'($urandom_range(0, 7)), pick_operand(), pick_operand(), 0);
        end
    endtask

    task automatic test_back_to_back();
        do_op("b2b_mul",  3'd0, 32'hFFFF_FFFD, 32'd7, 0);
        do_op("b2b_div",  3'd4, 32'd7, 32'hFFFF_FFFE, 0);
        do_op("b2b_remu", 3'd7, 32'hDEAD_BEEF, 32'd1000, 0);
        do_op("b2b_rem",  3'd6, 32'd7, 32'hFFFF_FFFE, 0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_directed();
        test_backpressure();
        test_flush();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
